// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with bundle fetch, redirect flush and multi-word dequeue
module fetch_queue #(
  parameter int          FETCH_WIDTH = 8,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] START_PC    = 32'h0000_3000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [31:0]                   imem_addr,
  input  logic [FETCH_WIDTH*32-1:0]     imem_data,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic [$clog2(FETCH_WIDTH):0]  deq_count,
  output logic [FETCH_WIDTH-1:0]        out_valid,
  output logic [FETCH_WIDTH*32-1:0]     out_instr,
  output logic [FETCH_WIDTH*32-1:0]     out_pc,
  output logic [$clog2(DEPTH):0]        occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = CW + 1;

  logic [31:0]   r_fetch_pc;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_inflight;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];

  logic [CW-1:0] w_deq_req;
  logic [CW-1:0] w_deq;
  logic [NW-1:0] w_need;
  logic          w_issue;
  logic          w_enq;
  logic [31:0]   w_resp_pc;

  assign w_deq_req = CW'(deq_count);
  assign w_deq     = redirect_valid ? '0 : ((w_deq_req > r_count) ? r_count : w_deq_req);

  // Room must cover this bundle plus any bundle still in flight; uses pre-dequeue count.
  assign w_need    = NW'(r_count) + (r_inflight ? NW'(2 * FETCH_WIDTH) : NW'(FETCH_WIDTH));
  assign w_issue   = !redirect_valid && (w_need <= NW'(DEPTH));
  assign w_enq     = r_inflight && !redirect_valid;

  // The response in flight was addressed one bundle before the current fetch_pc.
  assign w_resp_pc = r_fetch_pc - 32'(4 * FETCH_WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= START_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'(4 * FETCH_WIDTH);
      end
      r_inflight <= w_issue;
      if (w_enq) begin
        r_tail <= r_tail + PW'(FETCH_WIDTH);
      end
      r_head  <= r_head + w_deq[PW-1:0];
      r_count <= r_count + (w_enq ? CW'(FETCH_WIDTH) : '0) - w_deq;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        r_instr[r_tail + PW'(i)] <= imem_data[32*i +: 32];
        r_pc[r_tail + PW'(i)]    <= w_resp_pc + 32'(4 * i);
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_instr = '0;
    out_pc    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      out_valid[i]        = CW'(i) < r_count;
      out_instr[32*i +: 32] = r_instr[r_head + PW'(i)];
      out_pc[32*i +: 32]    = r_pc[r_head + PW'(i)];
    end
  end

  assign imem_addr = r_fetch_pc;
  assign occupancy = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;
  localparam int FW    = 8;
  localparam int DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [31:0]          imem_addr;
  logic [FW*32-1:0]     imem_data = '0;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic [3:0]           deq_count;
  logic [FW-1:0]        out_valid;
  logic [FW*32-1:0]     out_instr;
  logic [FW*32-1:0]     out_pc;
  logic [4:0]           occupancy;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .START_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_count(deq_count),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC3A5_0F1E;
  endfunction

  // Instruction memory: data for the address of cycle t appears in cycle t+1.
  always @(posedge clk) begin
    for (int i = 0; i < FW; i++) imem_data[32*i +: 32] <= instr_of(imem_addr + 32'(4 * i));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_stream(input logic [31:0] base);
    exp_q.delete();
    for (int k = 0; k < 512; k++) exp_q.push_back(base + 32'(4 * k));
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Every consumed word must be the next PC of the expected fetch stream.
  always @(negedge clk) begin : monitor
    int          n;
    logic [31:0] e;
    if (rst_n === 1'b1 && redirect_valid === 1'b0) begin
      n = (int'(deq_count) < int'(occupancy)) ? int'(deq_count) : int'(occupancy);
      for (int i = 0; i < n; i++) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got word %h expected none", out_pc[32*i +: 32]);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", out_pc[32*i +: 32], e);
          chk("sb_instr", out_instr[32*i +: 32], instr_of(e));
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    deq_count      = '0;
    repeat (3) cyc;
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_valid", 32'(out_valid), 0);

    load_stream(32'h3000);
    rst_n = 1'b1;
    chk("fill_addr0", imem_addr, 32'h3000);
    cyc; chk("fill_addr1", imem_addr, 32'h3020); chk("fill_occ1", 32'(occupancy), 0);
    cyc; chk("fill_addr2", imem_addr, 32'h3040); chk("fill_occ2", 32'(occupancy), 8);
    cyc; chk("fill_addr3", imem_addr, 32'h3040); chk("fill_occ3", 32'(occupancy), 16);
    cyc; chk("fill_addr4", imem_addr, 32'h3040); chk("fill_occ4", 32'(occupancy), 16);
    chk("fill_valid", 32'(out_valid), 32'hFF);
    chk("fill_pc0", out_pc[31:0], 32'h3000);

    deq_count = 3;
    cyc; chk("full_occ13", 32'(occupancy), 13); chk("full_pc0", out_pc[31:0], 32'h300C);
    chk("full_noissue", imem_addr, 32'h3040);
    deq_count = 5;
    cyc; chk("deq5_occ", 32'(occupancy), 8); chk("deq5_pc0", out_pc[31:0], 32'h3020);
    chk("deq5_addr", imem_addr, 32'h3040);
    deq_count = 0;
    cyc; chk("resume_addr", imem_addr, 32'h3060); chk("resume_occ", 32'(occupancy), 8);
    cyc; chk("resume_occ16", 32'(occupancy), 16); chk("resume_hold", imem_addr, 32'h3060);

    deq_count = 5;
    repeat (40) begin
      cyc;
      chk("stream_occ_max", 32'(occupancy <= 5'd16), 1);
    end

    deq_count = 0;
    repeat (6) cyc;
    chk("pre_redir_occ", 32'(occupancy), 16);
    deq_count = 8;
    cyc; chk("pre_redir_occ8", 32'(occupancy), 8);
    deq_count = 0;
    cyc;
    redirect_valid = 1'b1; redirect_pc = 32'h3100; deq_count = 3;
    cyc;
    redirect_valid = 1'b0; deq_count = 0;
    load_stream(32'h3100);
    chk("redir_occ", 32'(occupancy), 0);
    chk("redir_addr", imem_addr, 32'h3100);
    chk("redir_valid", 32'(out_valid), 0);
    cyc; chk("redir_stale_drop", 32'(occupancy), 0); chk("redir_addr2", imem_addr, 32'h3120);
    cyc; chk("redir_occ8", 32'(occupancy), 8); chk("redir_pc0", out_pc[31:0], 32'h3100);
    chk("redir_valid_ff", 32'(out_valid), 32'hFF);

    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    cyc;
    redirect_pc = 32'h5000;
    cyc;
    redirect_valid = 1'b0;
    load_stream(32'h5000);
    chk("b2b_addr", imem_addr, 32'h5000);
    chk("b2b_occ", 32'(occupancy), 0);
    cyc;
    cyc; chk("b2b_occ8", 32'(occupancy), 8); chk("b2b_pc0", out_pc[31:0], 32'h5000);
    chk("b2b_instr0", out_instr[31:0], instr_of(32'h5000));

    repeat (4) cyc;
    chk("clamp_full", 32'(occupancy), 16);
    deq_count = 3;
    cyc; chk("clamp_occ13", 32'(occupancy), 13);
    deq_count = 8;
    cyc; chk("clamp_occ5", 32'(occupancy), 5);
    cyc; chk("clamp_occ0", 32'(occupancy), 0); chk("clamp_valid0", 32'(out_valid), 0);
    deq_count = 0;
    cyc; chk("clamp_refill", 32'(occupancy), 8); chk("clamp_pc0", out_pc[31:0], 32'h5040);

    deq_count = 2;
    repeat (5) cyc;
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_valid", 32'(out_valid), 0);
    chk("pulse_occ", 32'(occupancy), 0);
    chk("pulse_addr", imem_addr, 32'h3000);
    load_stream(32'h3000);
    #1 rst_n = 1'b1;
    deq_count = 0;
    cyc; chk("pulse_addr1", imem_addr, 32'h3020);
    cyc; chk("pulse_occ8", 32'(occupancy), 8); chk("pulse_pc0", out_pc[31:0], 32'h3000);
    deq_count = 4;
    repeat (3) cyc;
    deq_count = 0;
    cyc;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
